calc_1: RTL and testbench
=========================

Name: calc_1

Overview:
- Four-port unsigned 32-bit calculator.
- Each requester port issues a command with a first operand, then a second operand on the following cycle.
- Each port receives a one-cycle response code plus a result on its own output pair.
- Ports are fully independent: four identical lanes run in parallel, with no arbitration and no shared state.

Parameters:
- None. Widths are fixed: data 32, cmd 4, resp 2, reset 7.

Ports:
- c_clk  in  1  rising-edge clock.
- reset  in  7 (bits [1:7])  asynchronous, active-high. Any bit high resets the whole block (OR of all bits).
- req1_cmd_in..req4_cmd_in  in  4 each, [0:3]  command per port.
- req1_data_in..req4_data_in  in  32 each, [0:31]  operand per port.
- out_data1..out_data4  out  32 each, [0:31]  result per port.
- out_resp1..out_resp4  out  2 each, [0:1]  response code per port.
- Bit 0 is the MSB on every vector. Values are unsigned.

Behaviour:
- Reset:
  - Asynchronous: all out_data = 0, all out_resp = 0, all lanes go to IDLE, any pending operand is discarded.
  - Reset asserted mid-operation drops that operation with no response.
- Command codes:
  - 0 = no-op
  - 1 = add
  - 2 = subtract (op1 - op2)
  - 5 = shift left logical
  - 6 = shift right logical
  - 3, 4, 7..15 = invalid
- Response codes:
  - 0 = no response this cycle
  - 1 = success
  - 2 = overflow / underflow / invalid command
  - 3 = reserved, never driven
- Per-lane FSM:
  - IDLE:
    - A nonzero cmd sampled at edge N latches cmd and op1 = data_in; go to OP2.
    - cmd = 0 stays in IDLE.
  - OP2:
    - At edge N+1, data_in is latched as op2, whatever cmd_in is (cmd_in is ignored in this cycle).
    - The result is computed and registered onto out_resp/out_data at that same edge; lane returns to IDLE.
  - Response timing: out_resp/out_data are valid for exactly one cycle (edge N+1 to edge N+2), then return to 0/0 unless a new result lands.
  - Back-to-back: a new command may be presented in the cycle right after the second operand, so sustained throughput is one operation per 2 cycles per lane.
- Arithmetic:
  - add: 33-bit sum.
    - Carry out set: resp 2, data 0.
    - Otherwise: resp 1, data = sum[31:0].
  - subtract:
    - op2 > op1: resp 2, data 0 (underflow).
    - Otherwise: resp 1, data = op1 - op2.
  - shift left: op1 << op2 low 5 bits (bits [27:31]); vacated bits are 0 and shifted-out bits are discarded. resp 1.
  - shift right: op1 >> op2 low 5 bits, logical. resp 1.
  - Shift amount 0 returns op1.
  - Invalid cmd: still occupies OP2 (second-cycle data ignored), then resp 2, data 0.
- Whenever resp is 2, data is 0.
- Lanes never interact. Simultaneous commands on all four ports each complete with identical latency.

Decomposition:
- Package calc_1_pkg:
  - cmd constants: CMD_NOP = 0, CMD_ADD = 1, CMD_SUB = 2, CMD_SHL = 5, CMD_SHR = 6.
  - resp constants: RESP_NONE = 0, RESP_OK = 1, RESP_ERR = 2.
  - lane state enum: IDLE, OP2.
- One sub-module, calc_1_lane:
  - Contains the FSM, operand registers and ALU for a single port.
  - Instantiated four times in calc_1. The top level only ORs the reset bits and wires the lanes.

Test Plan:
- Reset: hold reset[1] = 1 for 4 cycles, other bits 0 -> all out_resp = 0 and all out_data = 0, including during reset.
- Add: port1 cmd 1 with 0x00000001, then 0x1FFFFFFF -> one cycle later resp 1, data 0x20000000.
- Add: 0x1FFFFFFF + 0x1FFFFFFF -> resp 1, data 0x3FFFFFFE.
- Add: 0 + 0 -> resp 1, data 0.
- Add overflow: 0xFFFFFFFF + 0x00000001 -> resp 2, data 0.
- Add per bit: for each bit position x (1, 2, 4, ... 2^30), x + 0 -> resp 1, data x.
- Subtract underflow: cmd 2 with 1, then 15 -> resp 2, data 0.
- Subtract valid: 15 - 1 -> resp 1, data 14.
- Invalid commands: cmd 3, cmd 4 and cmd 15, each with data 1 -> resp 2, data 0.
- Shifts: cmd 5 with 0x00000001, then 31 -> resp 1, data 0x80000000.
- Shifts: cmd 6 with 0x80000000, then 4 -> resp 1, data 0x08000000.
- Shifts: cmd 5 with 0x80000000, then 1 -> resp 1, data 0.
- Concurrency: all four ports issue different adds in the same cycle -> all four responses appear in the same cycle, each correct.
- Concurrency: assert reset between op1 and op2 -> no response appears, and the lane accepts a new command after reset release.

Source files
------------

// File: rtl/calc_1_pkg.sv
// Shared types, constants and the lane ALU for the four-port calculator.
package calc_1_pkg;

  localparam int NUM_LANES = 4;
  localparam int DATA_W    = 32;
  localparam int CMD_W     = 4;
  localparam int RESP_W    = 2;
  localparam int RST_W     = 7;
  localparam int SHAMT_W   = 5;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    OP2  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } lane_req_t;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic [DATA_W-1:0] data;
  } lane_rsp_t;

  // Result of one operation; data stays 0 on every error path.
  function automatic lane_rsp_t alu(input logic [CMD_W-1:0]  cmd,
                                    input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    lane_rsp_t       r;
    logic [DATA_W:0] sum;
    r   = '0;
    sum = {1'b0, a} + {1'b0, b};
    case (cmd)
      CMD_ADD: begin
        if (sum[DATA_W]) r.resp = RESP_ERR;
        else begin
          r.resp = RESP_OK;
          r.data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (b > a) r.resp = RESP_ERR;
        else begin
          r.resp = RESP_OK;
          r.data = a - b;
        end
      end
      CMD_SHL: begin
        r.resp = RESP_OK;
        r.data = a << b[SHAMT_W-1:0];
      end
      CMD_SHR: begin
        r.resp = RESP_OK;
        r.data = a >> b[SHAMT_W-1:0];
      end
      default: r.resp = RESP_ERR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_1_lane.sv
// One calculator lane: two-cycle operand capture FSM, operand regs, ALU, response reg.
module calc_1_lane
  import calc_1_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  lane_req_t req,
  output lane_rsp_t rsp
);

  state_t            state, state_nxt;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] op1_q;
  logic              ld_op1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture command and first operand when a lane leaves IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q <= CMD_NOP;
      op1_q <= '0;
    end else if (ld_op1) begin
      cmd_q <= req.cmd;
      op1_q <= req.data;
    end
  end

  // Next state: a nonzero cmd starts an op; OP2 always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    ld_op1    = 1'b0;
    case (state)
      IDLE: begin
        if (req.cmd != CMD_NOP) begin
          ld_op1    = 1'b1;
          state_nxt = OP2;
        end
      end
      OP2:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response register: second operand goes straight into the ALU, result shows for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rsp <= '0;
    else if (state == OP2)  rsp <= alu(cmd_q, op1_q, req.data);
    else                    rsp <= '0;
  end

endmodule

// File: rtl/calc_1.sv
// Four-port calculator top: ORs the reset bits and wires four independent lanes.
module calc_1
  import calc_1_pkg::*;
(
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:31] out_data2,
  output logic [0:31] out_data3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp1,
  output logic [0:1]  out_resp2,
  output logic [0:1]  out_resp3,
  output logic [0:1]  out_resp4
);

  logic                        rst;
  lane_req_t [NUM_LANES-1:0]   req;
  lane_rsp_t [NUM_LANES-1:0]   rsp;

  assign rst = |reset;

  // Bit 0 is the MSB on the ports, so plain vector assignment keeps significance.
  assign req[0] = {req1_cmd_in, req1_data_in};
  assign req[1] = {req2_cmd_in, req2_data_in};
  assign req[2] = {req3_cmd_in, req3_data_in};
  assign req[3] = {req4_cmd_in, req4_data_in};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    calc_1_lane u_lane (
      .clk (c_clk),
      .rst (rst),
      .req (req[i]),
      .rsp (rsp[i])
    );
  end

  assign out_data1 = rsp[0].data;
  assign out_data2 = rsp[1].data;
  assign out_data3 = rsp[2].data;
  assign out_data4 = rsp[3].data;
  assign out_resp1 = rsp[0].resp;
  assign out_resp2 = rsp[1].resp;
  assign out_resp3 = rsp[2].resp;
  assign out_resp4 = rsp[3].resp;

endmodule

// File: tb/tb_calc_1.sv
// Bench for calc_1: directed cases plus randomized traffic against a behavioural model.
module tb_calc_1;

  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic [3:0]  cmd_a [4];
  logic [31:0] din_a [4];
  logic [31:0] od1, od2, od3, od4;
  logic [1:0]  or1, or2, or3, or4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 c_clk = ~c_clk;

  calc_1 dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_a[0]),
    .req2_cmd_in  (cmd_a[1]),
    .req3_cmd_in  (cmd_a[2]),
    .req4_cmd_in  (cmd_a[3]),
    .req1_data_in (din_a[0]),
    .req2_data_in (din_a[1]),
    .req3_data_in (din_a[2]),
    .req4_data_in (din_a[3]),
    .out_data1    (od1),
    .out_data2    (od2),
    .out_data3    (od3),
    .out_data4    (od4),
    .out_resp1    (or1),
    .out_resp2    (or2),
    .out_resp3    (or3),
    .out_resp4    (or4)
  );

  function automatic logic [31:0] g_data(int i);
    case (i)
      0: return od1;
      1: return od2;
      2: return od3;
      default: return od4;
    endcase
  endfunction

  function automatic logic [31:0] g_resp(int i);
    case (i)
      0: return {30'd0, or1};
      1: return {30'd0, or2};
      2: return {30'd0, or3};
      default: return {30'd0, or4};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Reference: what the calculator should answer, from plain integer arithmetic.
  task automatic ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] er, output logic [31:0] ed);
    logic [63:0] s;
    int          sh;
    er = 2; ed = 0;
    sh = int'(b % 32);
    case (c)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s <= 64'h0000_0000_FFFF_FFFF) begin er = 1; ed = s[31:0]; end
      end
      4'd2: if (a >= b) begin er = 1; ed = a - b; end
      4'd5: begin er = 1; ed = 32'(64'(a) * (64'd1 << sh)); end
      4'd6: begin er = 1; ed = a / (32'd1 << sh); end
      default: ;
    endcase
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      cmd_a[i] = 4'd0;
      din_a[i] = $urandom;
    end
  endtask

  task automatic chk_quiet(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_resp%0d", tag, i + 1), g_resp(i), 32'd0);
      chk($sformatf("%s_data%0d", tag, i + 1), g_data(i), 32'd0);
    end
  endtask

  // One directed op on lane ln with fixed expectations; junk on cmd during the second cycle.
  task automatic run_op(input int ln, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [31:0] ed,
                        input string tag);
    @(negedge c_clk);
    cmd_a[ln] = c;
    din_a[ln] = a;
    @(negedge c_clk);
    chk({tag, "_early"}, g_resp(ln), 32'd0);
    cmd_a[ln] = 4'($urandom);
    din_a[ln] = b;
    @(negedge c_clk);
    cmd_a[ln] = 4'd0;
    din_a[ln] = $urandom;
    chk({tag, "_resp"}, g_resp(ln), er);
    chk({tag, "_data"}, g_data(ln), ed);
    @(negedge c_clk);
    chk({tag, "_clr"}, g_resp(ln), 32'd0);
  endtask

  logic [3:0]  pc [4];
  logic [31:0] pa [4];
  logic [31:0] er [4];
  logic [31:0] ed [4];
  bit          pend [4];

  initial begin
    logic [31:0] x, b;
    logic [3:0]  c;
    int          r;

    reset = 7'b1000000;
    idle_all();
    for (int k = 0; k < 4; k++) begin
      @(negedge c_clk);
      chk_quiet($sformatf("rst%0d", k));
    end
    reset = '0;
    @(negedge c_clk);
    chk_quiet("post_rst");

    run_op(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 1, 32'h2000_0000, "add_a");
    run_op(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 1, 32'h3FFF_FFFE, "add_b");
    run_op(1, 4'd1, 32'h0,         32'h0,         1, 32'h0,         "add_zero");
    run_op(2, 4'd1, 32'hFFFF_FFFF, 32'h1,         2, 32'h0,         "add_ovf");
    x = 32'd1;
    for (int k = 0; k < 31; k++) begin
      run_op(k % 4, 4'd1, x, 32'h0, 1, x, $sformatf("add_bit%0d", k));
      x = x << 1;
    end
    run_op(0, 4'd2, 32'd1,  32'd15, 2, 32'd0,  "sub_unf");
    run_op(3, 4'd2, 32'd15, 32'd1,  1, 32'd14, "sub_ok");
    run_op(0, 4'd3,  32'd1, 32'd1, 2, 32'd0, "inv3");
    run_op(1, 4'd4,  32'd1, 32'd1, 2, 32'd0, "inv4");
    run_op(2, 4'd15, 32'd1, 32'd1, 2, 32'd0, "inv15");
    run_op(0, 4'd5, 32'h0000_0001, 32'd31, 1, 32'h8000_0000, "shl31");
    run_op(1, 4'd6, 32'h8000_0000, 32'd4,  1, 32'h0800_0000, "shr4");
    run_op(2, 4'd5, 32'h8000_0000, 32'd1,  1, 32'h0,         "shl_out");
    run_op(3, 4'd6, 32'h1234_5678, 32'd32, 1, 32'h1234_5678, "shr_wrap0");

    // All four ports add at once.
    @(negedge c_clk);
    for (int i = 0; i < 4; i++) begin cmd_a[i] = 4'd1; din_a[i] = 32'(100 * (i + 1)); end
    @(negedge c_clk);
    for (int i = 0; i < 4; i++) begin cmd_a[i] = 4'd0; din_a[i] = 32'(i + 1); end
    @(negedge c_clk);
    idle_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("conc_resp%0d", i + 1), g_resp(i), 32'd1);
      chk($sformatf("conc_data%0d", i + 1), g_data(i), 32'(101 * (i + 1)));
    end

    // Reset between op1 and op2 drops the op; lane then works normally.
    @(negedge c_clk);
    cmd_a[0] = 4'd1; din_a[0] = 32'd7;
    @(negedge c_clk);
    reset = 7'b0000100;
    cmd_a[0] = 4'd0; din_a[0] = 32'd9;
    @(negedge c_clk);
    chk_quiet("mid_rst");
    reset = '0;
    @(negedge c_clk);
    chk_quiet("mid_rst_rel");
    run_op(0, 4'd1, 32'd7, 32'd9, 1, 32'd16, "after_rst");

    // Randomized back-to-back traffic on all lanes.
    for (int i = 0; i < 4; i++) begin pend[i] = 0; er[i] = 0; ed[i] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge c_clk);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rnd%0d_l%0d_resp", cyc, i), g_resp(i), er[i]);
        chk($sformatf("rnd%0d_l%0d_data", cyc, i), g_data(i), ed[i]);
        b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        if (pend[i]) begin
          ref_op(pc[i], pa[i], b, er[i], ed[i]);
          pend[i]  = 0;
          cmd_a[i] = 4'($urandom);
          din_a[i] = b;
        end else begin
          r = $urandom_range(0, 9);
          case (r)
            1, 2:    c = 4'd1;
            3, 4:    c = 4'd2;
            5:       c = 4'd5;
            6:       c = 4'd6;
            7: begin
              c = 4'($urandom_range(3, 15));
              if (c == 4'd5 || c == 4'd6) c = 4'd7;
            end
            default: c = 4'd0;
          endcase
          cmd_a[i] = c;
          din_a[i] = b;
          er[i] = 0; ed[i] = 0;
          if (c != 4'd0) begin pend[i] = 1; pc[i] = c; pa[i] = b; end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
